fetch_queue: RTL and testbench

Instruction prefetch queue between a multi-cycle instruction memory and the IF/ID pipeline register of the RV32I pipelined core. It issues sequential fetch requests on a req/ack bus and buffers returned words with their PC and PC+4 in a DEPTH-entry FIFO. It presents the oldest entry to decode with a valid/ready handshake. A taken branch or jump from EX/MEM redirects it, flushing buffered entries and discarding any fetch already in flight.

---
 rtl/fetch_queue.sv | 176 +++++++++++++++++
 tb/tb_fetch_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between a multi-cycle instruction
// memory and the IF/ID register of the RV32I pipeline.
//
// Issues sequential fetches on a req/ack bus with at most one request in
// flight. Each returned word is buffered with its PC in a DEPTH-entry FIFO.
// The oldest entry is presented to decode with a valid/ready handshake.
// A redirect flushes the FIFO and restarts fetching at the new PC. A request
// already in flight is never withdrawn; its data is dropped when it returns.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   imem_req, imem_addr             registered fetch request / address (out)
//   imem_ack, imem_rdata            fetch completion and returned word (in)
//   redirect, redirect_pc           taken branch/jump and its target (in)
//   deq_ready                       decode accepts the head entry (in)
//   deq_valid, deq_pc,
//   deq_pc_plus_4, deq_instruction  head entry presented to decode (out)
//   count                           number of occupied entries (out)
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                        clk,
  input  logic                        rstn,
  output logic                        imem_req,
  output logic [DATA_WIDTH-1:0]       imem_addr,
  input  logic                        imem_ack,
  input  logic [DATA_WIDTH-1:0]       imem_rdata,
  input  logic                        redirect,
  input  logic [DATA_WIDTH-1:0]       redirect_pc,
  input  logic                        deq_ready,
  output logic                        deq_valid,
  output logic [DATA_WIDTH-1:0]       deq_pc,
  output logic [DATA_WIDTH-1:0]       deq_pc_plus_4,
  output logic [DATA_WIDTH-1:0]       deq_instruction,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no request outstanding
    S_WAIT = 2'd1,  // request outstanding, its data will be kept
    S_DROP = 2'd2   // request outstanding, its data predates a redirect
  } state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   fpc, fpc_nxt;
  logic                    req_nxt;
  logic [DATA_WIDTH-1:0]   addr_nxt;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count_r, count_nxt;
  logic                    push, pop, room;

  logic [DATA_WIDTH-1:0]   pc_mem  [DEPTH];
  logic [DATA_WIDTH-1:0]   ins_mem [DEPTH];

  // PC arithmetic wraps modulo 2^DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] pc_inc(input logic [DATA_WIDTH-1:0] pc);
    return pc + DATA_WIDTH'(4);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pc_align(input logic [DATA_WIDTH-1:0] pc);
    return pc & ~DATA_WIDTH'(3);
  endfunction

  assign deq_valid       = (count_r != '0);
  assign deq_pc          = pc_mem[rd_ptr];
  assign deq_pc_plus_4   = pc_inc(pc_mem[rd_ptr]);
  assign deq_instruction = ins_mem[rd_ptr];
  assign count           = count_r;

  // Redirect voids both the returning data and the decode handshake.
  assign push = (state == S_WAIT) && imem_ack && !redirect;
  assign pop  = deq_valid && deq_ready && !redirect;

  assign count_nxt = redirect ? '0 : (count_r + CNT_W'(push) - CNT_W'(pop));

  // A request is only issued when its data is guaranteed a slot on return:
  // while it is in flight the count can only fall.
  assign room = (count_nxt < CNT_W'(DEPTH));

  assign fpc_nxt = redirect ? pc_align(redirect_pc) :
                   push     ? pc_inc(imem_addr)     : fpc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      fpc       <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_nxt;
      fpc       <= fpc_nxt;
      imem_req  <= req_nxt;
      imem_addr <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (room) state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_ack)      state_nxt = room ? S_WAIT : S_IDLE;
        else if (redirect) state_nxt = S_DROP;
      end
      S_DROP: if (imem_ack) state_nxt = S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered request outputs. fpc_nxt already folds in
  // a redirect or the just-pushed address, so every issue point uses it.
  always_comb begin
    req_nxt  = imem_req;
    addr_nxt = imem_addr;
    case (state)
      S_IDLE: begin
        if (room) begin
          req_nxt  = 1'b1;
          addr_nxt = fpc_nxt;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          req_nxt  = room;
          addr_nxt = room ? fpc_nxt : imem_addr;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          req_nxt  = 1'b1;
          addr_nxt = fpc_nxt;
        end
      end
      default: begin
        req_nxt  = 1'b0;
        addr_nxt = imem_addr;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      count_r <= count_nxt;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Entries reset to zero so the head outputs are defined while empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]  <= imem_addr;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_pc;
  logic [31:0] deq_pc_plus_4;
  logic [31:0] deq_instruction;
  logic [2:0]  count;

  fetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .deq_ready       (deq_ready),
    .deq_valid       (deq_valid),
    .deq_pc          (deq_pc),
    .deq_pc_plus_4   (deq_pc_plus_4),
    .deq_instruction (deq_instruction),
    .count           (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  // Reference model: the program-order stream of instructions that decode
  // should see, plus the bus-level expectation for the next edge.
  ent_t        exp_q[$];
  logic [31:0] nxt_pc;
  logic        cur_stale;   // outstanding request predates a redirect
  logic        exp_req;
  logic        exp_issue;
  logic [31:0] held_addr;

  // Instruction memory model.
  logic        mem_busy;
  int          wait_cnt;

  logic        run = 1'b0;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    nxt_pc    = 32'h0;
    cur_stale = 1'b0;
    exp_req   = 1'b0;
    exp_issue = 1'b0;
    held_addr = 32'h0;
    mem_busy  = 1'b0;
    wait_cnt  = 0;
  endtask

  // Effect of the upcoming rising edge, evaluated just before it.
  task automatic model_edge();
    logic req, acked, pop_w;
    int   sz, sz_after;
    req   = imem_req;
    acked = req && imem_ack;
    sz    = exp_q.size();
    pop_w = (sz != 0) && deq_ready && !redirect;
    if (redirect) begin
      exp_q.delete();
      nxt_pc   = {redirect_pc[31:2], 2'b00};
      sz_after = 0;
    end else begin
      sz_after = sz - int'(pop_w);
      if (acked && !cur_stale) begin
        exp_q.push_back('{pc: nxt_pc, ins: mem_word(nxt_pc)});
        nxt_pc   = nxt_pc + 32'd4;
        sz_after = sz_after + 1;
      end
    end
    if (acked) mem_busy = 1'b0;
    else if (req && wait_cnt > 0) wait_cnt--;
    exp_issue = (!req || acked) && (sz_after < DEPTH);
    if (exp_issue) cur_stale = 1'b0;
    else if (req && !acked && redirect) cur_stale = 1'b1;
    held_addr = imem_addr;
    exp_req   = (req && !acked) || exp_issue;
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0103;
      1:       return 32'hFFFF_FFF5;
      2:       return 32'h0000_0200;
      default: return $urandom;
    endcase
  endfunction

  // Called at a falling edge; returns at a falling edge.
  task automatic run_cycles(input int n, input int rdy_pct, input int rdr_pct, input int max_lat);
    for (int c = 0; c < n; c++) begin
      if (imem_req && !mem_busy) begin
        mem_busy = 1'b1;
        wait_cnt = $urandom_range(0, max_lat);
      end
      if (imem_req) imem_ack = mem_busy && (wait_cnt == 0);
      else          imem_ack = 1'($urandom_range(0, 1));
      imem_rdata  = (imem_req && imem_ack) ? mem_word(imem_addr) : $urandom;
      deq_ready   = ($urandom_range(0, 99) < rdy_pct);
      redirect    = ($urandom_range(0, 99) < rdr_pct);
      redirect_pc = pick_pc();
      run = 1'b1;
      #3;
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic idle_inputs();
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    deq_ready   = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'h0);
    chk({tag, "_addr"},  imem_addr, 32'h0);
    chk({tag, "_valid"}, 32'(deq_valid), 32'h0);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_pc"},    deq_pc, 32'h0);
    chk({tag, "_pc4"},   deq_pc_plus_4, 32'h4);
    chk({tag, "_ins"},   deq_instruction, 32'h0);
  endtask

  // Monitor: post-edge bus and occupancy checks, pre-edge handshake pops.
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      #1;
      if (run) begin
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_issue)    chk("issue_addr", imem_addr, nxt_pc);
        else if (exp_req) chk("held_addr", imem_addr, held_addr);
        chk("count", 32'(count), 32'(exp_q.size()));
        chk("deq_valid", 32'(deq_valid), 32'(exp_q.size() != 0));
      end
      #8;
      if (run && deq_valid && deq_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          chk("deq_unexpected", deq_pc, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("deq_pc", deq_pc, e.pc);
          chk("deq_pc_plus_4", deq_pc_plus_4, e.pc + 32'd4);
          chk("deq_instruction", deq_instruction, e.ins);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");

    rstn = 1'b1;
    // Streaming: ack every cycle, decode always ready.
    run_cycles(40, 100, 0, 0);
    // Full stall, a single-cycle drain, then stall again.
    run_cycles(20, 0, 0, 0);
    run_cycles(1, 100, 0, 0);
    run_cycles(10, 0, 0, 0);
    // Mixed random traffic with variable latency and redirects.
    run_cycles(600, 60, 5, 3);
    run_cycles(300, 70, 15, 3);

    // Reset while a request is outstanding.
    for (int k = 0; k < 50 && !imem_req; k++) run_cycles(1, 50, 0, 3);
    run = 1'b0;
    idle_inputs();
    #1;
    rstn = 1'b0;
    #1;
    check_reset_state("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_cycles(250, 50, 5, 2);

    run = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
